usb_rst_sequencer: RTL
======================

USB_RST_SEQUENCER -- requirements
Module: usb_rst_sequencer

Interface
REQ-001 SHALL have parameter HOLD_W, default 16, meaning width of the reset-hold cycle count.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum consecutive waitrequest cycles tolerated per bus transfer.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning the reset: asynchronous, active-high.
REQ-005 SHALL have port start  input  1  meaning a one-cycle request to run one reset sequence.
REQ-006 SHALL have port hold_cycles  input  HOLD_W  meaning the number of cycles the reset stays asserted, sampled when start is accepted.
REQ-007 SHALL have port busy  output  1  meaning a sequence is in progress.
REQ-008 SHALL have port done  output  1  meaning a one-cycle pulse at the end of a sequence.
REQ-009 SHALL have port error  output  1  meaning the status of the last sequence, valid from done until the next accepted start.
REQ-010 SHALL have port avm_address  output  2  meaning the Avalon-MM master address; always 0.
REQ-011 SHALL have port avm_write  output  1  meaning the Avalon-MM write request.
REQ-012 SHALL have port avm_read  output  1  meaning the Avalon-MM read request.
REQ-013 SHALL have port avm_writedata  output  32  meaning the write data; only bit 0 is ever nonzero.
REQ-014 SHALL have port avm_readdata  input  32  meaning the read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-015 SHALL have port avm_waitrequest  input  1  meaning the slave stall; a transfer completes in the cycle the request is high and waitrequest is low.

Function
REQ-016 SHALL implement states IDLE, WR_ASSERT, HOLD, WR_RELEASE, RD_CHECK and FINISH.
REQ-017 SHALL, in IDLE, accept start=1 by latching hold_cycles, clearing error and entering WR_ASSERT on the next cycle.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL, in WR_ASSERT, drive avm_write=1 and avm_writedata=1, holding all master outputs stable until waitrequest=0, then enter HOLD.
REQ-021 SHALL, in HOLD, count the latched value down to completion, then enter WR_RELEASE; a latched value of 0 is treated as 1.
REQ-022 SHALL have exactly N cycles between the WR_ASSERT completion cycle and the first WR_RELEASE cycle, for N = max(latched hold_cycles, 1).
REQ-023 SHALL, in WR_RELEASE, drive avm_write=1 and avm_writedata=0 until waitrequest=0, then enter RD_CHECK.
REQ-024 SHALL, in RD_CHECK, drive avm_read=1 until waitrequest=0, sample avm_readdata[0] in that cycle, and then enter FINISH.
REQ-025 SHALL set error=1 if the sampled readdata[0] is not 0.
REQ-026 SHALL never assert avm_write and avm_read in the same cycle.
REQ-027 SHALL drive avm_write=0 and avm_read=0 outside the bus states.
REQ-028 SHALL count consecutive waitrequest=1 cycles in each bus state, resetting the count on each new transfer.
REQ-029 SHALL, when that count reaches TIMEOUT, deassert the request, set error=1 and enter FINISH directly.
REQ-030 SHALL, if a timeout occurs in WR_ASSERT or HOLD, still attempt one WR_RELEASE write before FINISH.
REQ-031 SHALL keep error=1 if that release write also times out.
REQ-032 SHALL, in FINISH, pulse done=1 for one cycle and return to IDLE.
REQ-033 SHALL allow a new start to be accepted in the IDLE cycle immediately after done.

Reset
REQ-034 SHALL, when reset=1, immediately force state IDLE and drive busy, done, error, avm_write, avm_read, avm_writedata and all counters to 0, without clock.
REQ-035 SHALL, if reset is asserted mid-transfer, abandon the sequence with no release write.
REQ-036 SHALL accept start from the first rising clk edge after reset deasserts.

Verification
REQ-037 SHALL be verified by: start, hold_cycles=4, waitrequest=0, readdata=0 -> write 1, exactly 4 HOLD cycles, write 0, one read, done pulse, error=0, busy high 8 cycles.
REQ-038 SHALL be verified by: waitrequest held 3 cycles on each transfer -> outputs stable while stalled, each transfer completes on the 4th cycle, error=0.
REQ-039 SHALL be verified by: hold_cycles=0 -> behaves identically to hold_cycles=1.
REQ-040 SHALL be verified by: readdata[0]=1 on RD_CHECK -> done with error=1.
REQ-041 SHALL be verified by: waitrequest stuck at 1 from WR_ASSERT with TIMEOUT=8 -> 8 stall cycles, release write attempted and timing out, done with error=1.
REQ-042 SHALL be verified by: reset pulsed during HOLD, and start re-pulsed while busy -> immediate all-zero outputs, IDLE; a start while busy is ignored.

Source files
------------

// File: rtl/usb_rst_sequencer.sv
// usb_rst_sequencer
// Drives one reset sequence over an Avalon-MM master port. The sequence writes 1 to the
// reset register, holds for a programmable number of cycles, writes 0, and then reads
// the register back to confirm that the reset has released.
//
// Ports:
//   clk             - single clock, rising edge
//   reset           - asynchronous, active-high reset
//   start           - one-cycle request to run a sequence (accepted only when idle)
//   hold_cycles     - reset hold length, sampled when start is accepted (0 behaves as 1)
//   busy            - a sequence is in progress
//   done            - one-cycle pulse at the end of a sequence
//   error           - status of the last sequence, valid from done until the next start
//   avm_*           - Avalon-MM master (address always 0, only writedata[0] ever set)

module usb_rst_sequencer #(
  parameter int unsigned HOLD_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrAssert,
    StHold,
    StWrRelease,
    StRdCheck,
    StFinish
  } state_e;

  state_e              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_write;
  logic                r_read;
  logic                r_wdata;

  logic                w_timeout;
  logic                w_unused_rdata;

  // The current stalled cycle is the TIMEOUT-th consecutive one.
  assign w_timeout      = avm_waitrequest && (r_wait == WAIT_W'(TIMEOUT - 1));
  assign w_unused_rdata = ^avm_readdata[31:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_hold  <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_wdata <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_hold  <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_write <= 1'b1;
            r_wdata <= 1'b1;
            r_wait  <= '0;
            r_state <= StWrAssert;
          end
        end

        StWrAssert: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_wdata <= 1'b0;
            r_state <= StHold;
          end else if (w_timeout) begin
            // Drop the request for one cycle, then still try to release the reset.
            r_write <= 1'b0;
            r_wdata <= 1'b0;
            r_error <= 1'b1;
            r_hold  <= HOLD_W'(1);
            r_state <= StHold;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        StHold: begin
          if (r_hold == HOLD_W'(1)) begin
            r_write <= 1'b1;
            r_wdata <= 1'b0;
            r_wait  <= '0;
            r_state <= StWrRelease;
          end else begin
            r_hold <= r_hold - HOLD_W'(1);
          end
        end

        StWrRelease: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_read  <= 1'b1;
            r_wait  <= '0;
            r_state <= StRdCheck;
          end else if (w_timeout) begin
            r_write <= 1'b0;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StFinish;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        StRdCheck: begin
          if (!avm_waitrequest) begin
            r_read <= 1'b0;
            // Sticky: an earlier timeout must not be cleared by a good readback.
            if (avm_readdata[0]) begin
              r_error <= 1'b1;
            end
            r_done  <= 1'b1;
            r_state <= StFinish;
          end else if (w_timeout) begin
            r_read  <= 1'b0;
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_state <= StFinish;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        StFinish: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end

        default: begin
          r_busy  <= 1'b0;
          r_write <= 1'b0;
          r_read  <= 1'b0;
          r_wdata <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign avm_address   = 2'd0;
  assign avm_write     = r_write;
  assign avm_read      = r_read;
  assign avm_writedata = {31'd0, r_wdata};

endmodule
